// File: rtl/fb_line_engine.sv
// Bresenham line sequencer for the 640x480 1-bit framebuffer: one write request per
// on-screen pixel through a req/ready port, off-screen pixels stepped through unwritten.
module fb_line_engine #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int XW    = 10,
    parameter int YW    = 9,
    parameter int AW    = 19
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y1,
    input  logic          colour,
    input  logic          fb_ready,
    output logic          fb_we,
    output logic [AW-1:0] fb_addr,
    output logic          fb_wdata,
    output logic          busy,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

    localparam logic [XW-1:0] X_LIM = XW'(H_RES);
    localparam logic [YW-1:0] Y_LIM = YW'(V_RES);

    state_t               state_q;
    logic [XW-1:0]        cx_q, x1_q, cx_d;
    logic [YW-1:0]        cy_q, y1_q, cy_d;
    logic signed [11:0]   dx_q, dy_q, err_q, err_d;
    logic                 sx_neg_q, sy_neg_q, colour_q;
    logic                 fb_we_q, fb_wdata_q, busy_q, done_q;
    logic [AW-1:0]        fb_addr_q;

    logic [11:0]          x0e, x1e, y0e, y1e, dx_abs, dy_abs;
    logic signed [12:0]   e2, dx13, dy13;
    logic                 step_x, step_y, at_end, step_done;

    // Row stride 640 = 512 + 128, so the address needs only shifts and adds.
    function automatic logic [AW-1:0] addr_of(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return (AW'(y) << 9) + (AW'(y) << 7) + AW'(x);
    endfunction

    function automatic logic on_screen(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return (x < X_LIM) && (y < Y_LIM);
    endfunction

    always_comb begin
        x0e    = 12'(cx_q);
        x1e    = 12'(x1_q);
        y0e    = 12'(cy_q);
        y1e    = 12'(y1_q);
        dx_abs = (x1e >= x0e) ? (x1e - x0e) : (x0e - x1e);
        dy_abs = (y1e >= y0e) ? (y1e - y0e) : (y0e - y1e);

        e2     = {err_q, 1'b0};
        dx13   = {dx_q[11], dx_q};
        dy13   = {dy_q[11], dy_q};
        step_x = (e2 >= dy13);
        step_y = (e2 <= dx13);

        // Both corrections are taken from the pre-step error term.
        err_d  = err_q + (step_x ? dy_q : 12'sd0) + (step_y ? dx_q : 12'sd0);
        cx_d   = cx_q;
        cy_d   = cy_q;
        if (step_x) cx_d = sx_neg_q ? cx_q - 1'b1 : cx_q + 1'b1;
        if (step_y) cy_d = sy_neg_q ? cy_q - 1'b1 : cy_q + 1'b1;

        at_end    = (cx_q == x1_q) && (cy_q == y1_q);
        step_done = !fb_we_q || fb_ready;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= IDLE;
            cx_q       <= '0;
            cy_q       <= '0;
            x1_q       <= '0;
            y1_q       <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            err_q      <= '0;
            sx_neg_q   <= 1'b0;
            sy_neg_q   <= 1'b0;
            colour_q   <= 1'b0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_wdata_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        cx_q     <= x0;
                        cy_q     <= y0;
                        x1_q     <= x1;
                        y1_q     <= y1;
                        colour_q <= colour;
                        busy_q   <= 1'b1;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    dx_q       <= dx_abs;
                    dy_q       <= -dy_abs;
                    err_q      <= dx_abs - dy_abs;
                    sx_neg_q   <= !(cx_q < x1_q);
                    sy_neg_q   <= !(cy_q < y1_q);
                    fb_we_q    <= on_screen(cx_q, cy_q);
                    fb_addr_q  <= addr_of(cx_q, cy_q);
                    fb_wdata_q <= colour_q;
                    state_q    <= DRAW;
                end
                DRAW: begin
                    if (step_done) begin
                        if (at_end) begin
                            fb_we_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            cx_q      <= cx_d;
                            cy_q      <= cy_d;
                            err_q     <= err_d;
                            fb_we_q   <= on_screen(cx_d, cy_d);
                            fb_addr_q <= addr_of(cx_d, cy_d);
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fb_we    = fb_we_q;
    assign fb_addr  = fb_addr_q;
    assign fb_wdata = fb_wdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: doc/fb_line_engine.md
Name: fb_line_engine

Overview:
- Hardware line-drawing controller for the 640x480 1-bit frame buffer.
- Software programs two endpoints and a colour, then pulses start. The block sequences Bresenham stepping and issues one framebuffer write per on-screen pixel.
- Writes go through a request/ready port into the framebuffer write arbiter, which shares the memory with AHB writes.
- Frees the M0 from per-pixel stores when drawing triangle edges.

Parameters:
- H_RES, 640, visible pixels per line; also the row stride.
- V_RES, 480, visible lines.
- XW, 10, x coordinate width.
- YW, 9, y coordinate width.
- AW, 19, framebuffer address width.

Ports:
- HCLK  input  1  system clock, rising edge.
- HRESET  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a line; sampled only in IDLE.
- x0  input  XW  start x; captured on accepted start.
- y0  input  YW  start y; captured on accepted start.
- x1  input  XW  end x; captured on accepted start.
- y1  input  YW  end y; captured on accepted start.
- colour  input  1  pixel value to write; captured on accepted start.
- fb_ready  input  1  arbiter accepts the write in this cycle.
- fb_we  output  1  write request.
- fb_addr  output  AW  y*H_RES+x of current pixel.
- fb_wdata  output  1  captured colour.
- busy  output  1  high from the cycle after accepted start until the cycle after done.
- done  output  1  one-cycle pulse when the final pixel completes.

Behaviour:
- Reset (any time, including mid-line):
  - state=IDLE; fb_we=0, fb_addr=0, fb_wdata=0, busy=0, done=0.
  - Internal registers are cleared and no write is issued afterwards.
- States: IDLE, SETUP, DRAW, DONE.
- IDLE:
  - start=1 captures endpoints and colour, then goes to SETUP.
  - start is ignored in all other states (no queueing).
- SETUP (1 cycle):
  - dx=|x1-x0|, dy=-|y1-y0|, err=dx+dy, all signed 12-bit.
  - sx=+1 if x0<x1 else -1; sy=+1 if y0<y1 else -1.
  - Current point (cx,cy)=(x0,y0). Goes to DRAW.
- DRAW, one pixel per step:
  - On-screen point (cx<H_RES and cy<V_RES): fb_we=1, fb_addr=cy*H_RES+cx, fb_wdata=colour.
    - fb_addr is computed as (cy<<9)+(cy<<7)+cx, no multiplier.
    - fb_we, fb_addr and fb_wdata are held stable until a cycle with fb_ready=1. That cycle completes the step.
  - Off-screen point: fb_we=0; the step completes in one cycle (clipped, no write).
- Step completion:
  - If (cx,cy)==(x1,y1), go to DONE.
  - Otherwise e2=2*err:
    - if e2>=dy: err+=dy, cx+=sx.
    - if e2<=dx: err+=dx, cy+=sy.
    - Both updates use the old err and apply in the same cycle.
- Pixel count is max(dx,-dy)+1; both endpoints are inclusive.
- Coordinates are compared unsigned at full width; no wrap past 0 occurs because stepping ends at the endpoint.
- DONE: done=1 for one cycle, fb_we=0, then IDLE. busy drops in the IDLE cycle.
- Latency:
  - start in cycle N, SETUP in N+1, first fb_we in N+2.
  - With fb_ready tied high and all points on-screen: one pixel per cycle, and done appears the cycle after the last write.
- fb_we is never asserted outside DRAW and never for an off-screen coordinate.
- Degenerate line (x0,y0)==(x1,y1): exactly one write, then done.

Test Plan:
- Horizontal line (0,0)->(3,0), colour=1, fb_ready=1: fb_addr 0,1,2,3 with fb_we=1 on cycles N+2..N+5; done=1 at N+6; busy low at N+7.
- Steep negative line (5,5)->(2,1), fb_ready=1: addresses 3205, 2564, 1923, 1283, 642 in order, then done.
- Backpressure on (10,2)->(11,2): fb_ready low 3 cycles at the first pixel. fb_addr must hold 1290 with fb_we=1, then 1290 and 1291 are accepted; exactly 2 writes total.
- Clipping (638,0)->(641,0): writes only at 638 and 639; two no-write cycles follow; done after 4 steps.
- Single point (639,479): one write at 307199; done. A start pulse during busy is ignored, with no second line.
- HRESET asserted mid-DRAW of (0,0)->(100,0): fb_we, busy and done drop to 0 immediately. After release, state is IDLE and no writes occur until the next start.
